// File: rtl/rom_sequencer.sv
// rom_sequencer
//   Address sequencer feeding the LED-driver control ROM. A frame optionally
//   runs one special-mode pass (addr 32..63, driver configuration) and then
//   LAYERS normal-mode passes (addr 0..31). Each address is held for CLK_DIV
//   clocks. Frames are requested through a start/busy/done handshake.
//
//   Optional feature macro: ROM_SPECIAL_MODE_EN
//     defined   : CFG pass and sticky cfg_pending flag are present; the first
//                 frame after reset always configures the drivers.
//     undefined : no CFG pass, cfg_req ignored, addr[5] tied to 0.
//
//   Parameters
//     CLK_DIV  clocks each address is held (1..256)
//     LAYERS   normal-mode passes per frame (1..16)
//
//   Ports
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     start    frame request, sampled only while idle
//     cfg_req  one-cycle pulse requesting a CFG pass before the next frame
//     addr     ROM address (registered)
//     layer    index of the current normal pass (registered)
//     busy     high for the whole frame
//     done     one-cycle pulse on the first idle cycle after a frame
module rom_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int LAYERS  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       cfg_req,
    output logic [5:0] addr,
    output logic [3:0] layer,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [3:0] LAST_LAYER = 4'(LAYERS - 1);

`ifdef ROM_SPECIAL_MODE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd2
    } state_t;
`endif

    state_t     state;
    logic [7:0] presc;
    logic [4:0] addr_lo;
    logic       addr_hi;
    logic       tick;

    // addr is kept as a 5-bit pass offset plus a page bit; the page bit only
    // exists as a register when the special mode is built in.
    assign addr = {addr_hi, addr_lo};
    assign tick = (presc == 8'd0);

`ifdef ROM_SPECIAL_MODE_EN
    logic cfg_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr_hi     <= 1'b0;
            addr_lo     <= '0;
            layer       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            presc       <= DIV_LOAD;
            cfg_pending <= 1'b1;
        end else begin
            done <= 1'b0;
            if (cfg_req) begin
                cfg_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        presc   <= DIV_LOAD;
                        busy    <= 1'b1;
                        addr_lo <= '0;
                        // A request arriving with start is consumed by this frame.
                        if (cfg_pending || cfg_req) begin
                            state       <= CFG;
                            addr_hi     <= 1'b1;
                            cfg_pending <= 1'b0;
                        end else begin
                            state   <= RUN;
                            addr_hi <= 1'b0;
                            layer   <= '0;
                        end
                    end
                end
                CFG: begin
                    if (tick) begin
                        presc <= DIV_LOAD;
                        if (addr_lo == 5'd31) begin
                            state   <= RUN;
                            addr_hi <= 1'b0;
                            addr_lo <= '0;
                            layer   <= '0;
                        end else begin
                            addr_lo <= addr_lo + 5'd1;
                        end
                    end else begin
                        presc <= presc - 8'd1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc <= DIV_LOAD;
                        if (addr_lo == 5'd31) begin
                            if (layer == LAST_LAYER) begin
                                // Park at 31 so the display stays on the latched data.
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                layer   <= layer + 4'd1;
                                addr_lo <= '0;
                            end
                        end else begin
                            addr_lo <= addr_lo + 5'd1;
                        end
                    end else begin
                        presc <= presc - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_cfg_req;

    assign addr_hi        = 1'b0;
    assign unused_cfg_req = cfg_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_lo <= '0;
            layer   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            presc   <= DIV_LOAD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        presc   <= DIV_LOAD;
                        busy    <= 1'b1;
                        addr_lo <= '0;
                        layer   <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc <= DIV_LOAD;
                        if (addr_lo == 5'd31) begin
                            if (layer == LAST_LAYER) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                layer   <= layer + 4'd1;
                                addr_lo <= '0;
                            end
                        end else begin
                            addr_lo <= addr_lo + 5'd1;
                        end
                    end else begin
                        presc <= presc - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rom_sequencer.sv
// Testbench for rom_sequencer. Two instances: A (CLK_DIV=2, LAYERS=2) and
// B (CLK_DIV=1, LAYERS=1). Expected address/layer streams are generated per
// frame into a queue and popped on every busy cycle.
module tb_rom_sequencer;

`ifdef ROM_SPECIAL_MODE_EN
    localparam bit CFG_ON = 1'b1;
`else
    localparam bit CFG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, cfg_req, sel;
    logic start_a, start_b, cfg_a, cfg_b;
    logic [5:0] addr_a, addr_b, addr_o;
    logic [3:0] layer_a, layer_b, layer_o;
    logic busy_a, busy_b, busy_o, done_a, done_b, done_o;

    assign start_a = sel ? 1'b0 : start;
    assign start_b = sel ? start : 1'b0;
    assign cfg_a   = sel ? 1'b0 : cfg_req;
    assign cfg_b   = sel ? cfg_req : 1'b0;
    assign addr_o  = sel ? addr_b  : addr_a;
    assign layer_o = sel ? layer_b : layer_a;
    assign busy_o  = sel ? busy_b  : busy_a;
    assign done_o  = sel ? done_b  : done_a;

    rom_sequencer #(.CLK_DIV(2), .LAYERS(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .cfg_req(cfg_a),
        .addr(addr_a), .layer(layer_a), .busy(busy_a), .done(done_a)
    );

    rom_sequencer #(.CLK_DIV(1), .LAYERS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .cfg_req(cfg_b),
        .addr(addr_b), .layer(layer_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int addr;
        int layer;   // -1: not checked (CFG pass)
    } exp_t;

    typedef struct {
        bit cfg_with_start;
        bit mid_start;
        bit mid_cfg;
        bit cfg_pass;
        int busy_cycles;
    } vec_t;

    exp_t sb[$];
    vec_t vecs_a[6];
    vec_t vecs_b[2];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_frame(input bit with_cfg, input int div, input int layers);
        exp_t e;
        if (with_cfg) begin
            for (int a = 32; a < 64; a++)
                for (int k = 0; k < div; k++) begin
                    e.addr = a; e.layer = -1; sb.push_back(e);
                end
        end
        for (int l = 0; l < layers; l++)
            for (int a = 0; a < 32; a++)
                for (int k = 0; k < div; k++) begin
                    e.addr = a; e.layer = l; sb.push_back(e);
                end
    endtask

    // Called and returns at posedge+1.
    task automatic run_frame(input vec_t v, input int div, input int layers);
        int   nb;
        bit   finished;
        bit   cfg_sent;
        exp_t e;
        nb = 0; finished = 0; cfg_sent = 0;
        sb.delete();
        push_frame(v.cfg_pass, div, layers);
        start   = 1'b1;
        cfg_req = v.cfg_with_start;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            cfg_req = 1'b0;
            if (busy_o) begin
                nb++;
                if (sb.size() == 0) begin
                    check("frame_too_long", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("addr", int'(addr_o), e.addr);
                    if (e.layer >= 0) check("layer", int'(layer_o), e.layer);
                end
                check("done_while_busy", int'(done_o), 0);
                if (v.mid_start && nb == 50) start = 1'b1;
                if (v.mid_cfg && !cfg_sent && layer_o == 4'd1 && addr_o == 6'd10) begin
                    cfg_req  = 1'b1;
                    cfg_sent = 1'b1;
                end
            end else begin
                if (nb == 0) check("busy_after_start", 0, 1);
                finished = 1;
                break;
            end
        end
        if (!finished) check("frame_timeout", 0, 1);
        check("done_pulse", int'(done_o), 1);
        check("park_addr", int'(addr_o), 31);
        check("busy_len", nb, v.busy_cycles);
        check("sb_empty", sb.size(), 0);
        if (v.mid_cfg) check("mid_cfg_sent", int'(cfg_sent), 1);
        @(posedge clk); #1;
        check("done_single", int'(done_o), 0);
        check("park_hold", int'(addr_o), 31);
        check("idle_busy", int'(busy_o), 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; cfg_req = 1'b0; sel = 1'b0;

        vecs_a[0] = '{1'b0, 1'b0, 1'b0, CFG_ON, CFG_ON ? 192 : 128}; // first frame configures
        vecs_a[1] = '{1'b0, 1'b1, 1'b0, 1'b0,   128};                // mid-frame start ignored
        vecs_a[2] = '{1'b0, 1'b0, 1'b1, 1'b0,   128};                // cfg_req at layer1/addr10
        vecs_a[3] = '{1'b0, 1'b0, 1'b0, CFG_ON, CFG_ON ? 192 : 128}; // deferred CFG pass
        vecs_a[4] = '{1'b1, 1'b0, 1'b0, CFG_ON, CFG_ON ? 192 : 128}; // cfg_req with start
        vecs_a[5] = '{1'b0, 1'b0, 1'b0, 1'b0,   128};
        vecs_b[0] = '{1'b1, 1'b0, 1'b0, CFG_ON, CFG_ON ? 64 : 32};
        vecs_b[1] = '{1'b0, 1'b0, 1'b0, 1'b0,   32};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_addr_a",  int'(addr_a),  0);
            check("rst_layer_a", int'(layer_a), 0);
            check("rst_busy_a",  int'(busy_a),  0);
            check("rst_done_a",  int'(done_a),  0);
            check("rst_addr_b",  int'(addr_b),  0);
            check("rst_busy_b",  int'(busy_b),  0);
        end

        for (int i = 0; i < 6; i++) run_frame(vecs_a[i], 2, 2);

        // Asynchronous reset in the middle of a frame.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            bit hit;
            hit = 0;
            for (int c = 0; c < 500; c++) begin
                if (addr_a == 6'd17 && layer_a == 4'd1) begin
                    hit = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("reach_17_l1", int'(hit), 1);
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst_addr",  int'(addr_a),  0);
        check("arst_layer", int'(layer_a), 0);
        check("arst_busy",  int'(busy_a),  0);
        check("arst_done",  int'(done_a),  0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("arst_no_done", int'(done_a), 0);
            check("arst_idle",    int'(busy_a), 0);
        end
        run_frame('{1'b0, 1'b0, 1'b0, CFG_ON, CFG_ON ? 192 : 128}, 2, 2);

        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) run_frame(vecs_b[i], 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
